// File: rtl/countdown5_seq.sv
// countdown5_seq: iteration counter / controller for the multi-cycle datapath.
// Loads the upstream operand on start, steps it toward the terminal value
// (0 counting down, all-ones counting up), then pulses done together with
// reg_en so the upstream operand register captures its next value.
module countdown5_seq #(
    parameter int unsigned WIDTH = 32'd5,
    parameter bit          UP    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic             step,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             reg_en
);

    // Terminal value and the value one count before it in the count direction.
    localparam logic [WIDTH-1:0] TERM     = UP ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] PRE_TERM = UP ? {{(WIDTH-1){1'b1}}, 1'b0}
                                               : {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_next_s;
    logic             busy_r;
    logic             done_r;
    logic             reg_en_r;

    // One count toward the terminal value; modulo 2^WIDTH by construction.
    function automatic logic [WIDTH-1:0] count_step(input logic [WIDTH-1:0] value);
        logic [WIDTH-1:0] one;
        one = {{(WIDTH-1){1'b0}}, 1'b1};
        if (UP) begin
            count_step = value + one;
        end else begin
            count_step = value - one;
        end
    endfunction

    // Next-state and next-count decode; clr always wins over start/step.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (clr) begin
                    state_next_s = IDLE;
                    cnt_next_s   = {WIDTH{1'b0}};
                end else if (start) begin
                    cnt_next_s = a;
                    if (a == TERM) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = RUN;
                    end
                end else begin
                    state_next_s = IDLE;
                    cnt_next_s   = cnt_r;
                end
            end
            RUN: begin
                if (clr) begin
                    state_next_s = IDLE;
                    cnt_next_s   = {WIDTH{1'b0}};
                end else if (step) begin
                    cnt_next_s = count_step(cnt_r);
                    if (cnt_r == PRE_TERM) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = RUN;
                    end
                end else begin
                    state_next_s = RUN;
                    cnt_next_s   = cnt_r;
                end
            end
            DONE: begin
                // The done cycle itself is already committed in the output
                // registers; clr only affects where we land afterwards.
                state_next_s = IDLE;
                if (clr) begin
                    cnt_next_s = {WIDTH{1'b0}};
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = {WIDTH{1'b0}};
            end
        endcase
    end

    // State, count and registered status outputs; async reset clears all at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            cnt_r    <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            reg_en_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            cnt_r    <= cnt_next_s;
            busy_r   <= (state_next_s != IDLE);
            done_r   <= (state_next_s == DONE);
            reg_en_r <= (state_next_s == DONE);
        end
    end

    assign cnt    = cnt_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign reg_en = reg_en_r;
    assign zero   = (cnt_r == TERM);

endmodule

// File: tb/tb_countdown5_seq.sv
// Directed bench for countdown5_seq: a down-counting and an up-counting
// instance share clock and reset; expected values are hand-computed.
module tb_countdown5_seq;

    logic       clk;
    logic       rst;

    logic       start_dn, step_dn, clr_dn;
    logic [4:0] a_dn;
    logic [4:0] cnt_dn;
    logic       busy_dn, done_dn, zero_dn, reg_en_dn;

    logic       start_up, step_up, clr_up;
    logic [4:0] a_up;
    logic [4:0] cnt_up;
    logic       busy_up, done_up, zero_up, reg_en_up;

    int n_checks;
    int n_fail;
    int done_seen;

    countdown5_seq #(.WIDTH(32'd5), .UP(1'b0)) u_dn (
        .clk(clk), .rst(rst), .start(start_dn), .a(a_dn), .step(step_dn),
        .clr(clr_dn), .cnt(cnt_dn), .busy(busy_dn), .done(done_dn),
        .zero(zero_dn), .reg_en(reg_en_dn)
    );

    countdown5_seq #(.WIDTH(32'd5), .UP(1'b1)) u_up (
        .clk(clk), .rst(rst), .start(start_up), .a(a_up), .step(step_up),
        .clr(clr_up), .cnt(cnt_up), .busy(busy_up), .done(done_up),
        .zero(zero_up), .reg_en(reg_en_up)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_dn(input string tag, input int c, input bit b, input bit d);
        check_eq({tag, ".cnt"}, 32'(cnt_dn), 32'(c));
        check_eq({tag, ".busy"}, 32'(busy_dn), 32'(b));
        check_eq({tag, ".done"}, 32'(done_dn), 32'(d));
        check_eq({tag, ".reg_en"}, 32'(reg_en_dn), 32'(d));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        start_dn = 1'b0; step_dn = 1'b0; clr_dn = 1'b0; a_dn = 5'd0;
        start_up = 1'b0; step_up = 1'b0; clr_up = 1'b0; a_up = 5'd0;

        // Reset state
        tick(); tick();
        check_dn("reset", 0, 1'b0, 1'b0);
        check_eq("reset.zero_dn", 32'(zero_dn), 32'd1);
        check_eq("reset.cnt_up", 32'(cnt_up), 32'd0);
        check_eq("reset.zero_up", 32'(zero_up), 32'd0);
        rst = 1'b1;
        tick();
        check_dn("idle", 0, 1'b0, 1'b0);

        // Basic run: a=5, step held high
        a_dn = 5'd5; start_dn = 1'b1; step_dn = 1'b1;
        tick();
        start_dn = 1'b0;
        check_dn("run5.load", 5, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_dn($sformatf("run5.s%0d", i), 5 - i, 1'b1, (i == 5));
        end
        check_eq("run5.zero", 32'(zero_dn), 32'd1);
        tick();
        check_dn("run5.idle", 0, 1'b0, 1'b0);

        // Zero operand: straight to DONE
        a_dn = 5'd0; start_dn = 1'b1;
        tick();
        start_dn = 1'b0;
        check_dn("zero_op.done", 0, 1'b1, 1'b1);
        tick();
        check_dn("zero_op.idle", 0, 1'b0, 1'b0);

        // Step gating 1,0,0,1,1 with start pulses (a=7) ignored in RUN
        a_dn = 5'd3; start_dn = 1'b1; step_dn = 1'b0;
        tick();
        start_dn = 1'b0;
        check_dn("gate.load", 3, 1'b1, 1'b0);
        step_dn = 1'b1; tick(); check_dn("gate.s1", 2, 1'b1, 1'b0);
        a_dn = 5'd7; start_dn = 1'b1;
        step_dn = 1'b0; tick(); check_dn("gate.s2", 2, 1'b1, 1'b0);
        step_dn = 1'b0; tick(); check_dn("gate.s3", 2, 1'b1, 1'b0);
        start_dn = 1'b0;
        step_dn = 1'b1; tick(); check_dn("gate.s4", 1, 1'b1, 1'b0);
        step_dn = 1'b1; tick(); check_dn("gate.s5", 0, 1'b1, 1'b1);
        step_dn = 1'b0; tick(); check_dn("gate.idle", 0, 1'b0, 1'b0);

        // Abort at cnt=15 with step also high
        a_dn = 5'd20; start_dn = 1'b1; step_dn = 1'b1;
        tick();
        start_dn = 1'b0;
        for (int i = 1; i <= 5; i++) tick();
        check_dn("abort.pre", 15, 1'b1, 1'b0);
        clr_dn = 1'b1;
        tick();
        clr_dn = 1'b0; step_dn = 1'b0;
        check_dn("abort.clr", 0, 1'b0, 1'b0);
        tick();
        check_dn("abort.after", 0, 1'b0, 1'b0);

        // clr in DONE: done cycle completes, then IDLE with cnt cleared
        a_dn = 5'd0; start_dn = 1'b1;
        tick();
        start_dn = 1'b0; clr_dn = 1'b1;
        check_dn("clr_done.done", 0, 1'b1, 1'b1);
        tick();
        check_dn("clr_done.idle", 0, 1'b0, 1'b0);

        // clr beats start in IDLE
        a_dn = 5'd9; start_dn = 1'b1; clr_dn = 1'b1;
        tick();
        start_dn = 1'b0; clr_dn = 1'b0;
        check_dn("clr_idle", 0, 1'b0, 1'b0);

        // Async reset mid-RUN at cnt=10
        a_dn = 5'd31; start_dn = 1'b1; step_dn = 1'b1;
        tick();
        start_dn = 1'b0;
        check_dn("areset.load", 31, 1'b1, 1'b0);
        for (int i = 1; i <= 21; i++) tick();
        check_dn("areset.pre", 10, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_dn("areset.now", 0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            done_seen += int'(done_dn) + int'(reg_en_dn);
        end
        check_eq("areset.no_done", 32'(done_seen), 32'd0);
        check_dn("areset.idle", 0, 1'b0, 1'b0);
        step_dn = 1'b0;

        // UP=1: a=29 counts 29,30,31
        a_up = 5'd29; start_up = 1'b1; step_up = 1'b1;
        tick();
        start_up = 1'b0;
        check_eq("up29.c0", 32'(cnt_up), 32'd29);
        check_eq("up29.busy", 32'(busy_up), 32'd1);
        check_eq("up29.zero0", 32'(zero_up), 32'd0);
        tick();
        check_eq("up29.c1", 32'(cnt_up), 32'd30);
        check_eq("up29.done1", 32'(done_up), 32'd0);
        tick();
        check_eq("up29.c2", 32'(cnt_up), 32'd31);
        check_eq("up29.done2", 32'(done_up), 32'd1);
        check_eq("up29.reg_en2", 32'(reg_en_up), 32'd1);
        check_eq("up29.zero2", 32'(zero_up), 32'd1);
        tick();
        check_eq("up29.idle_busy", 32'(busy_up), 32'd0);
        check_eq("up29.idle_done", 32'(done_up), 32'd0);
        check_eq("up29.idle_cnt", 32'(cnt_up), 32'd31);

        // UP=1: a=31 is terminal, done one cycle after start
        a_up = 5'd31; start_up = 1'b1;
        tick();
        start_up = 1'b0; step_up = 1'b0;
        check_eq("up31.done", 32'(done_up), 32'd1);
        check_eq("up31.cnt", 32'(cnt_up), 32'd31);
        tick();
        check_eq("up31.idle", 32'(done_up), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
